// File: rtl/conv_pkg.sv
// Shared definitions for the 4x4-input / 3x3-filter convolution sequencer:
// dimensions, derived widths and the controller state encoding.
package conv_pkg;

    localparam int IN_DIM  = 4;                          // input image side
    localparam int K_DIM   = 3;                          // filter side
    localparam int DATA_W  = 8;                          // pixel / coefficient width
    localparam int ACC_W   = 20;                         // accumulator / result width
    localparam int OUT_DIM = IN_DIM - K_DIM + 1;         // valid output grid side

    localparam int ADDR_W  = $clog2(IN_DIM * IN_DIM);    // element index width
    localparam int K_W     = $clog2(K_DIM);              // kr / kc counter width
    localparam int POS_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;  // orow / ocol width
    localparam int PROD_W  = 2 * DATA_W;                 // unsigned product width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// Window walker: filter tap counters (kr, kc) nested inside output position
// counters (orow, ocol), plus the input/filter address arithmetic and the
// first/last flags the controller needs.
module conv_addr_gen
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic              clr_i,        // return all counters to zero
    input  logic              tap_en_i,     // step to the next filter tap
    input  logic              pos_en_i,     // step to the next output position
    output logic [ADDR_W-1:0] in_addr_o,
    output logic [ADDR_W-1:0] flt_addr_o,
    output logic [POS_W-1:0]  orow_o,
    output logic [POS_W-1:0]  ocol_o,
    output logic              first_tap_o,
    output logic              last_tap_o,
    output logic              last_pos_o
);

    localparam logic [K_W-1:0]   K_LAST   = K_W'(K_DIM - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(OUT_DIM - 1);

    logic [K_W-1:0]   kr_q, kr_d, kc_q, kc_d;
    logic [POS_W-1:0] orow_q, orow_d, ocol_q, ocol_d;

    // Next-state for the counters: kc fastest, then kr; ocol fastest, then orow.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        kr_d   = kr_q;
        kc_d   = kc_q;
        orow_d = orow_q;
        ocol_d = ocol_q;
        if (clr_i) begin
            kr_d   = '0;
            kc_d   = '0;
            orow_d = '0;
            ocol_d = '0;
        end else begin
            if (tap_en_i) begin
                if (kc_q == K_LAST) begin
                    kc_d = '0;
                    kr_d = (kr_q == K_LAST) ? '0 : kr_q + 1'b1;
                end else begin
                    kc_d = kc_q + 1'b1;
                end
            end
            if (pos_en_i) begin
                if (ocol_q == POS_LAST) begin
                    ocol_d = '0;
                    orow_d = (orow_q == POS_LAST) ? '0 : orow_q + 1'b1;
                end else begin
                    ocol_d = ocol_q + 1'b1;
                end
            end
        end
    end

    // Counter registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kr_q   <= '0;
            kc_q   <= '0;
            orow_q <= '0;
            ocol_q <= '0;
        end else begin
            kr_q   <= kr_d;
            kc_q   <= kc_d;
            orow_q <= orow_d;
            ocol_q <= ocol_d;
        end
    end

    // Window offset applied to the input index; filter index is row-major.
    assign in_addr_o   = ADDR_W'((int'(orow_q) + int'(kr_q)) * IN_DIM
                                 + int'(ocol_q) + int'(kc_q));
    assign flt_addr_o  = ADDR_W'(int'(kr_q) * K_DIM + int'(kc_q));

    assign orow_o      = orow_q;
    assign ocol_o      = ocol_q;
    assign first_tap_o = (kr_q == '0) && (kc_q == '0);
    assign last_tap_o  = (kr_q == K_LAST) && (kc_q == K_LAST);
    assign last_pos_o  = (orow_q == POS_LAST) && (ocol_q == POS_LAST);

endmodule

// File: rtl/conv_sequencer.sv
// Convolution controller: walks the output grid, multiplies-accumulates the
// nine window products per position and offers each result on a valid/ready
// port. Optional feature macro: CONV_STALL_CNT_EN adds a saturating count of
// back-pressured output cycles on port stall_cnt.
module conv_sequencer
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,          // asynchronous, active-low
    input  logic              start,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] flt_addr,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic [DATA_W-1:0] flt_coef,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [POS_W-1:0]  out_row,
    output logic [POS_W-1:0]  out_col,
    output logic              done
`ifdef CONV_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    state_e              state_q, state_d;
    logic                clr, tap_en, pos_en;
    logic                first_tap, last_tap, last_pos;
    logic [PROD_W-1:0]   prod;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    out_data_q, out_data_d;

    conv_addr_gen u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .tap_en_i    (tap_en),
        .pos_en_i    (pos_en),
        .in_addr_o   (in_addr),
        .flt_addr_o  (flt_addr),
        .orow_o      (out_row),
        .ocol_o      (out_col),
        .first_tap_o (first_tap),
        .last_tap_o  (last_tap),
        .last_pos_o  (last_pos)
    );

    // FSM next state and control strobes; start is only looked at in IDLE.
    always_comb begin
        state_d   = state_q;
        clr       = 1'b0;
        tap_en    = 1'b0;
        pos_en    = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    clr     = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                tap_en = 1'b1;
                if (last_tap) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pos_en  = 1'b1;
                    state_d = last_pos ? DONE : MAC;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Unsigned product, zero-extended into the accumulator width.
    assign prod = in_pixel * flt_coef;

    // First tap loads the accumulator, later taps add; the last tap's sum is
    // captured into the output register so it holds through any stall.
    always_comb begin
        acc_d      = acc_q;
        out_data_d = out_data_q;
        if (tap_en) begin
            acc_d = (first_tap ? '0 : acc_q) + ACC_W'(prod);
            if (last_tap) out_data_d = acc_d;
        end
    end

    // Accumulator and output data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

`ifdef CONV_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of offered-but-refused output cycles; cleared on an accepted start.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr)
            stall_cnt_d = '0;
        else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomised scoreboard bench for conv_sequencer: the stimulus side fills the
// image/filter memories, computes the expected results and address sequence
// from the convolution definition and queues them; a monitor compares every
// offered result and every MAC-cycle address against the queues.
module tb_conv_sequencer;
    import conv_pkg::*;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic [POS_W-1:0] row;
        logic [POS_W-1:0] col;
    } exp_res_t;

    typedef struct packed {
        logic [ADDR_W-1:0] ia;
        logic [ADDR_W-1:0] fa;
    } exp_addr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] in_addr, flt_addr;
    logic [DATA_W-1:0] in_pixel, flt_coef;
    logic              busy, out_valid, out_ready, done;
    logic [ACC_W-1:0]  out_data;
    logic [POS_W-1:0]  out_row, out_col;
`ifdef CONV_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    logic [DATA_W-1:0] img [16];
    logic [DATA_W-1:0] flt [16];
    logic [DATA_W-1:0] img_save [16];
    logic [DATA_W-1:0] flt_save [16];

    exp_res_t  exp_q  [$];
    exp_addr_t addr_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_valid_cyc = 0;
    int start_cyc = 0;
    int stall_len = 0;
    bit rand_ready = 1'b0;

    conv_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_addr   (in_addr),
        .flt_addr  (flt_addr),
        .in_pixel  (in_pixel),
        .flt_coef  (flt_coef),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .done      (done)
`ifdef CONV_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational register-memory read, as the top-level address muxes provide.
    assign in_pixel = img[in_addr];
    assign flt_coef = flt[flt_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Consumer: either random ready, or hold ready low for stall_len cycles at each offer.
    initial begin : ready_driver
        int held;
        held = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if (out_valid && held < stall_len) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = 1'b1;
                if (!out_valid) held = 0;
            end
        end
    end

    // Monitor: results, MAC addresses, stall stability and done pulses.
    initial begin : monitor
        logic              was_stalled;
        logic [ADDR_W-1:0] stall_ia;
        logic [ACC_W-1:0]  stall_data;
        logic              prev_valid;
        exp_res_t          e;
        exp_addr_t         a;
        was_stalled = 1'b0;
        stall_ia    = '0;
        stall_data  = '0;
        prev_valid  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                was_stalled = 1'b0;
                prev_valid  = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_valid && exp_q.size() == 4) first_valid_cyc = cyc;
                    if (was_stalled) begin
                        check("stall_in_addr_stable", 32'(in_addr), 32'(stall_ia));
                        check("stall_data_stable", 32'(out_data), 32'(stall_data));
                    end
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q[0];
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_row", 32'(out_row), 32'(e.row));
                        check("out_col", 32'(out_col), 32'(e.col));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                    was_stalled = !out_ready;
                    stall_ia    = in_addr;
                    stall_data  = out_data;
                end else begin
                    was_stalled = 1'b0;
                end
                prev_valid = out_valid;
                if (busy && !out_valid && !done) begin
                    if (addr_q.size() == 0) begin
                        check("unexpected_mac_cycle", 32'(busy), 32'd0);
                    end else begin
                        a = addr_q.pop_front();
                        check("in_addr", 32'(in_addr), 32'(a.ia));
                        check("flt_addr", 32'(flt_addr), 32'(a.fa));
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_with_pending_results", 32'(exp_q.size()), 32'd0);
                end
            end
        end
    end

    task automatic fill_mem(input int mode);  // 0 random, 1 all ones
        for (int i = 0; i < 16; i++) begin
            img[i] = (mode == 1) ? 8'hFF : 8'($urandom);
            flt[i] = (mode == 1) ? 8'hFF : 8'($urandom);
        end
    endtask

    // Reference model: direct sum over the window for every output position.
    task automatic push_expected();
        exp_res_t  e;
        exp_addr_t a;
        int        sum;
        for (int r = 0; r < OUT_DIM; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                sum = 0;
                for (int kr = 0; kr < K_DIM; kr++) begin
                    for (int kc = 0; kc < K_DIM; kc++) begin
                        a.ia = ADDR_W'((r + kr) * IN_DIM + c + kc);
                        a.fa = ADDR_W'(kr * K_DIM + kc);
                        addr_q.push_back(a);
                        sum += int'(img[(r + kr) * IN_DIM + c + kc]) * int'(flt[kr * K_DIM + kc]);
                    end
                end
                e.data = ACC_W'(sum);
                e.row  = POS_W'(r);
                e.col  = POS_W'(c);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_conv(input bit check_lat);
        int d0;
        d0 = done_cnt;
        push_expected();
        pulse_start();
        wait_done();
        check("busy_in_done", 32'(busy), 32'd1);
        if (check_lat) begin
            check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd9);
            check("done_latency", 32'(done_cyc - start_cyc), 32'd40);
        end
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin : stimulus
        int d0, n;

        // Reset values.
        fill_mem(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_addr", 32'(in_addr), 32'd0);
        check("rst_flt_addr", 32'(flt_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_row", 32'(out_row), 32'd0);
        check("rst_out_col", 32'(out_col), 32'd0);
        rst = 1'b1;

        // Basic run with latency checks; keep the memory image for the reset test.
        for (int i = 0; i < 16; i++) begin
            img_save[i] = img[i];
            flt_save[i] = flt[i];
        end
        run_conv(1'b1);

        // Largest operands: 9 * 255 * 255 must fit without overflow.
        fill_mem(1);
        run_conv(1'b1);

        // Back-pressure at every offer; results and addresses must hold.
        fill_mem(0);
        stall_len = 7;
        run_conv(1'b0);
        stall_len = 0;

        // start re-pulsed during MAC and in the DONE cycle is ignored.
        fill_mem(0);
        d0 = done_cnt;
        push_expected();
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (15) @(negedge clk);
        check("no_restart_busy", 32'(busy), 32'd0);
        check("single_done_pulse", 32'(done_cnt - d0), 32'd1);

        // Reset during MAC of position (1,0), then a fresh run on the first image.
        for (int i = 0; i < 16; i++) begin
            img[i] = img_save[i];
            flt[i] = flt_save[i];
        end
        d0 = done_cnt;
        push_expected();
        pulse_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && !out_valid && out_row == 1'b1 && out_col == 1'b0) && n < 200);
        check("reached_pos_1_0", 32'(out_row), 32'd1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_addr", 32'(in_addr), 32'd0);
        check("midrst_flt_addr", 32'(flt_addr), 32'd0);
        check("midrst_out_row", 32'(out_row), 32'd0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        rst = 1'b1;
        run_conv(1'b1);

`ifdef CONV_STALL_CNT_EN
        // Five refused cycles at each of the four offers, then cleared by a new start.
        fill_mem(0);
        stall_len = 5;
        push_expected();
        pulse_start();
        wait_done();
        check("stall_cnt_at_done", 32'(stall_cnt), 32'd20);
        stall_len = 0;
        @(negedge clk);
        push_expected();
        pulse_start();
        @(negedge clk);
        check("stall_cnt_cleared", 32'(stall_cnt), 32'd0);
        wait_done();
        check("stall_cnt_no_stalls", 32'(stall_cnt), 32'd0);
        @(negedge clk);
`endif

        // Random images with a random consumer.
        rand_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            fill_mem(0);
            run_conv(1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rand_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("results_left", 32'(exp_q.size()), 32'd0);
        check("addrs_left", 32'(addr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
